load_store_unit: RTL and testbench

Load/store front end that sits between the core's execute stage and the shared word-wide inferred RAM. It accepts one byte-addressed RISC-V load or store request at a time and issues word accesses on the RAM's write port and read port A; read port B stays with instruction fetch. Sub-word stores are done as read-modify-write, and loads are sign- or zero-extended. Misaligned, illegal or out-of-range accesses return a fault instead of touching memory.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store front end between execute and the shared word-wide RAM.
// Every request runs IDLE -> READ -> EXTRACT -> RESPOND; sub-word stores are read-modify-write.
module load_store_unit #(
    parameter int RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   requestValid,
    output logic                   requestReady,
    input  logic                   requestWrite,
    input  logic [31:0]            requestAddress,
    input  logic [2:0]             requestFunct3,
    input  logic [31:0]            requestData,
    output logic                   responseValid,
    output logic [31:0]            responseData,
    output logic                   responseFault,
    output logic [RAM_A_WIDTH-1:0] ramWriteAddress,
    output logic [31:0]            ramDataIn,
    output logic                   ramWriteEnable,
    output logic [RAM_A_WIDTH-1:0] ramReadAddress,
    input  logic [31:0]            ramDataOut,
    output logic [1:0]             debugState
);

    // Handshake: a request transfers on a rising edge where requestValid && requestReady;
    // requestReady is high only in IDLE, and responseValid is a one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        EXTRACT = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic [31:0] response_data_q, response_data_d;
    logic        response_valid_q, response_valid_d;
    logic        response_fault_q, response_fault_d;

    logic        accept;
    logic        req_misaligned;
    logic        req_illegal;
    logic        req_out_of_range;
    logic        store_commit;
    logic [31:0] merged_word;
    logic [31:0] load_value;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign accept = requestValid && (state_q == IDLE);

    always_comb begin
        req_misaligned = ((requestFunct3[1:0] == 2'b01) && requestAddress[0]) ||
                         ((requestFunct3[1:0] == 2'b10) && (requestAddress[1:0] != 2'b00));
        req_illegal = (requestFunct3 == 3'b011) || (requestFunct3 == 3'b110) ||
                      (requestFunct3 == 3'b111) || (requestWrite && requestFunct3[2]);
        req_out_of_range = |requestAddress[31:RAM_A_WIDTH+2];
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        data_d   = data_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = READ;
                    write_d  = requestWrite;
                    addr_d   = requestAddress;
                    funct3_d = requestFunct3;
                    data_d   = requestData;
                    fault_d  = req_misaligned || req_illegal || req_out_of_range;
                end
            end
            READ:    state_d = EXTRACT;
            EXTRACT: state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ramDataOut holds the old word during EXTRACT; lanes are little-endian.
    always_comb begin
        lane_byte = ramDataOut[{addr_q[1:0], 3'b000} +: 8];
        lane_half = ramDataOut[{addr_q[1], 4'b0000} +: 16];

        merged_word = ramDataOut;
        case (funct3_q[1:0])
            2'b00:   merged_word[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            2'b01:   merged_word[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: merged_word = data_q;
        endcase

        case (funct3_q)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_value = {24'h000000, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_value = {16'h0000, lane_half};
            3'b010:  load_value = ramDataOut;
            default: load_value = 32'h0000_0000;
        endcase
    end

    always_comb begin
        response_data_d  = response_data_q;
        response_valid_d = (state_q == EXTRACT);
        response_fault_d = (state_q == EXTRACT) ? fault_q : 1'b0;
        if (state_q == EXTRACT) begin
            response_data_d = (write_q || fault_q) ? 32'h0000_0000 : load_value;
        end
    end

    // Write enable is combinational so an asynchronous reset kills it within the cycle.
    assign store_commit   = (state_q == EXTRACT) && write_q && !fault_q;
    assign ramWriteEnable = store_commit;
    assign ramDataIn      = store_commit ? merged_word : 32'h0000_0000;

    assign ramReadAddress  = addr_q[RAM_A_WIDTH+1:2];
    assign ramWriteAddress = addr_q[RAM_A_WIDTH+1:2];
    assign requestReady    = (state_q == IDLE);
    assign responseValid   = response_valid_q;
    assign responseData    = response_data_q;
    assign responseFault   = response_fault_q;
    assign debugState      = state_q;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            addr_q           <= 32'h0000_0000;
            funct3_q         <= 3'b000;
            data_q           <= 32'h0000_0000;
            fault_q          <= 1'b0;
            response_data_q  <= 32'h0000_0000;
            response_valid_q <= 1'b0;
            response_fault_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            addr_q           <= addr_d;
            funct3_q         <= funct3_d;
            data_q           <= data_d;
            fault_q          <= fault_d;
            response_data_q  <= response_data_d;
            response_valid_q <= response_valid_d;
            response_fault_q <= response_fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM (registered read, 1-cycle latency).
module tb_load_store_unit;

    localparam int AW = 12;

    logic          clock;
    logic          nReset;
    logic          requestValid;
    logic          requestReady;
    logic          requestWrite;
    logic [31:0]   requestAddress;
    logic [2:0]    requestFunct3;
    logic [31:0]   requestData;
    logic          responseValid;
    logic [31:0]   responseData;
    logic          responseFault;
    logic [AW-1:0] ramWriteAddress;
    logic [31:0]   ramDataIn;
    logic          ramWriteEnable;
    logic [AW-1:0] ramReadAddress;
    logic [31:0]   ramDataOut;
    logic [1:0]    debugState;

    logic [31:0] mem [0:(1<<AW)-1];
    int          we_count;
    int          resp_count;
    int          n_checks;
    int          n_fail;

    load_store_unit #(.RAM_A_WIDTH(AW)) dut (
        .clock          (clock),
        .nReset         (nReset),
        .requestValid   (requestValid),
        .requestReady   (requestReady),
        .requestWrite   (requestWrite),
        .requestAddress (requestAddress),
        .requestFunct3  (requestFunct3),
        .requestData    (requestData),
        .responseValid  (responseValid),
        .responseData   (responseData),
        .responseFault  (responseFault),
        .ramWriteAddress(ramWriteAddress),
        .ramDataIn      (ramDataIn),
        .ramWriteEnable (ramWriteEnable),
        .ramReadAddress (ramReadAddress),
        .ramDataOut     (ramDataOut),
        .debugState     (debugState)
    );

    // Clock and RAM model
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ramWriteEnable) begin
            mem[ramWriteAddress] <= ramDataIn;
            we_count <= we_count + 1;
        end
        if (responseValid) resp_count <= resp_count + 1;
        ramDataOut <= mem[ramReadAddress];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request from IDLE through RESPOND, checking timing, response and write count.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_fault);
        int we_start;
        @(negedge clock);
        requestValid   = 1'b1;
        requestWrite   = wr;
        requestAddress = addr;
        requestFunct3  = f3;
        requestData    = data;
        we_start       = we_count;
        check({tag, "_ready_idle"}, {31'd0, requestReady}, 32'd1);
        @(posedge clock); #1;
        requestValid = 1'b0;
        check({tag, "_ready_busy"}, {31'd0, requestReady}, 32'd0);
        check({tag, "_rv_e1"}, {31'd0, responseValid}, 32'd0);
        @(posedge clock); #1;
        check({tag, "_we_extract"}, {31'd0, ramWriteEnable}, {31'd0, wr && !exp_fault});
        @(posedge clock); #1;
        check({tag, "_rv_e2"}, {31'd0, responseValid}, 32'd1);
        check({tag, "_data"}, responseData, exp_data);
        check({tag, "_fault"}, {31'd0, responseFault}, {31'd0, exp_fault});
        @(posedge clock); #1;
        check({tag, "_rv_e3"}, {31'd0, responseValid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, requestReady}, 32'd1);
        check({tag, "_writes"}, we_count - we_start, {31'd0, wr && !exp_fault});
    endtask

    initial begin
        logic [31:0] exp_rsp [0:2];
        int          rsp_idx;
        int          we_before;
        int          resp_before;

        n_checks = 0;
        n_fail = 0;
        we_count = 0;
        resp_count = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[16] = 32'h8899AABB;
        mem[17] = 32'h11111111;
        mem[18] = 32'h22222222;
        mem[19] = 32'h33333333;
        mem[20] = 32'hA5A5A5A5;

        requestValid = 1'b0;
        requestWrite = 1'b0;
        requestAddress = 32'h0;
        requestFunct3 = 3'b000;
        requestData = 32'h0;

        // Reset values
        nReset = 1'b0;
        #3;
        check("rst_ready", {31'd0, requestReady}, 32'd1);
        check("rst_rv", {31'd0, responseValid}, 32'd0);
        check("rst_rdata", responseData, 32'h0);
        check("rst_rfault", {31'd0, responseFault}, 32'd0);
        check("rst_we", {31'd0, ramWriteEnable}, 32'd0);
        check("rst_din", ramDataIn, 32'h0);
        check("rst_waddr", {20'd0, ramWriteAddress}, 32'h0);
        check("rst_raddr", {20'd0, ramReadAddress}, 32'h0);
        check("rst_state", {30'd0, debugState}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        nReset = 1'b1;

        // Loads from 0x8899AABB
        do_req("lb43",  1'b0, 32'h43, 3'b000, 32'h0, 32'hFFFFFF88, 1'b0);
        do_req("lbu43", 1'b0, 32'h43, 3'b100, 32'h0, 32'h00000088, 1'b0);
        do_req("lh42",  1'b0, 32'h42, 3'b001, 32'h0, 32'hFFFF8899, 1'b0);
        do_req("lhu40", 1'b0, 32'h40, 3'b101, 32'h0, 32'h0000AABB, 1'b0);
        do_req("lw40",  1'b0, 32'h40, 3'b010, 32'h0, 32'h8899AABB, 1'b0);
        do_req("lb41",  1'b0, 32'h41, 3'b000, 32'h0, 32'hFFFFFFAA, 1'b0);

        // Sub-word stores
        do_req("sb41", 1'b1, 32'h41, 3'b000, 32'h12345677, 32'h0, 1'b0);
        check("sb41_mem", mem[16], 32'h889977BB);
        do_req("sh42", 1'b1, 32'h42, 3'b001, 32'h0000CAFE, 32'h0, 1'b0);
        check("sh42_mem", mem[16], 32'hCAFE77BB);
        do_req("sw40", 1'b1, 32'h40, 3'b010, 32'h01020304, 32'h0, 1'b0);
        check("sw40_mem", mem[16], 32'h01020304);
        do_req("lbu41", 1'b0, 32'h41, 3'b100, 32'h0, 32'h00000003, 1'b0);

        // Faults
        do_req("f_lw42",  1'b0, 32'h42,   3'b010, 32'h0,        32'h0, 1'b1);
        do_req("f_sh41",  1'b1, 32'h41,   3'b001, 32'hDEADBEEF, 32'h0, 1'b1);
        check("f_sh41_mem", mem[16], 32'h01020304);
        do_req("f_f3_011", 1'b0, 32'h40,  3'b011, 32'h0,        32'h0, 1'b1);
        do_req("f_sb_100", 1'b1, 32'h40,  3'b100, 32'hFFFFFFFF, 32'h0, 1'b1);
        check("f_sb100_mem", mem[16], 32'h01020304);
        do_req("f_lw4000", 1'b0, 32'h4000, 3'b010, 32'h0,       32'h0, 1'b1);
        do_req("f_sw4000", 1'b1, 32'h4000, 3'b010, 32'h55555555, 32'h0, 1'b1);
        check("f_sw4000_mem0", mem[0], 32'h0);

        // Back-to-back with requestValid held; addresses offered while busy must be ignored
        exp_rsp[0] = 32'h01020304;
        exp_rsp[1] = 32'h11111111;
        exp_rsp[2] = 32'h22222222;
        rsp_idx = 0;
        requestWrite = 1'b0;
        requestFunct3 = 3'b010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            requestValid = 1'b1;
            case (i)
                0:       requestAddress = 32'h40;
                4:       requestAddress = 32'h44;
                8:       requestAddress = 32'h48;
                default: requestAddress = 32'h4C;
            endcase
            check($sformatf("b2b_ready_e%0d", i), {31'd0, requestReady}, {31'd0, (i % 4) == 0});
            @(posedge clock); #1;
            check($sformatf("b2b_rv_e%0d", i), {31'd0, responseValid}, {31'd0, (i % 4) == 2});
            if ((i % 4) == 2) begin
                check($sformatf("b2b_data_%0d", rsp_idx), responseData, exp_rsp[rsp_idx]);
                rsp_idx++;
            end
        end
        @(negedge clock);
        requestValid = 1'b0;
        @(posedge clock); #1;
        check("b2b_idle_after", {31'd0, requestReady}, 32'd1);

        // Reset during the EXTRACT cycle of an SB
        @(negedge clock);
        requestValid = 1'b1;
        requestWrite = 1'b1;
        requestAddress = 32'h50;
        requestFunct3 = 3'b000;
        requestData = 32'h0000005A;
        we_before = we_count;
        resp_before = resp_count;
        @(posedge clock); #1;
        requestValid = 1'b0;
        @(posedge clock); #1;
        check("rst_mid_we_before", {31'd0, ramWriteEnable}, 32'd1);
        check("rst_mid_din_before", ramDataIn, 32'hA5A5A55A);
        #2;
        nReset = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, ramWriteEnable}, 32'd0);
        check("rst_mid_din", ramDataIn, 32'h0);
        check("rst_mid_ready", {31'd0, requestReady}, 32'd1);
        check("rst_mid_waddr", {20'd0, ramWriteAddress}, 32'h0);
        check("rst_mid_rdata", responseData, 32'h0);
        check("rst_mid_state", {30'd0, debugState}, 32'd0);
        @(posedge clock);
        @(posedge clock); #1;
        check("rst_mid_mem", mem[20], 32'hA5A5A5A5);
        check("rst_mid_writes", we_count - we_before, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        #1;
        check("rst_mid_ready_after", {31'd0, requestReady}, 32'd1);
        @(posedge clock);
        @(posedge clock); #1;
        check("rst_mid_no_resp", resp_count - resp_before, 32'd0);
        check("rst_mid_rv", {31'd0, responseValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
